countdown_timer: RTL and testbench

//   BCD MM:SS countdown core fed by the 1 Hz divider output (ClkOut level, treated as data, never as a clock).

---
 rtl/countdown_pkg.sv | 33 +++
 rtl/cd_tick_sync.sv | 37 +++
 rtl/countdown_timer.sv | 140 ++++++++++++++
 tb/tb_countdown_timer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
//   Shared types and constants for the BCD MM:SS countdown core.
//   - cd_state_t : controller states
//   - bcd4       : one BCD digit
//   - bcd_clamp  : saturates a raw {min,sec} BCD load value into 00:00..99:59
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } cd_state_t;

    typedef logic [3:0] bcd4;

    localparam bcd4 BCD_MAX_UNITS = 4'd9;
    localparam bcd4 BCD_MAX_SECT  = 4'd5;

    // Each digit saturates independently; seconds tens saturate at 5.
    function automatic logic [15:0] bcd_clamp(input logic [7:0] mins,
                                              input logic [7:0] secs);
        bcd4 mt, mu, st, su;
        mt = (mins[7:4] > BCD_MAX_UNITS) ? BCD_MAX_UNITS : mins[7:4];
        mu = (mins[3:0] > BCD_MAX_UNITS) ? BCD_MAX_UNITS : mins[3:0];
        st = (secs[7:4] > BCD_MAX_SECT)  ? BCD_MAX_SECT  : secs[7:4];
        su = (secs[3:0] > BCD_MAX_UNITS) ? BCD_MAX_UNITS : secs[3:0];
        return {mt, mu, st, su};
    endfunction

endpackage

// File: rtl/cd_tick_sync.sv
// -----------------------------------------------------------------------------
// cd_tick_sync
//   Brings the 1 Hz divider level into the Clk domain and turns each 0->1
//   transition into a single-cycle pulse.
// Ports
//   Clk        in  system clock
//   Rst        in  synchronous, active-high reset (clears chain and edge flop)
//   Tick       in  divider output level (data, not a clock)
//   TickPulse  out high for one Clk cycle per rising edge of Tick
// Parameters
//   SYNC_STAGES  synchroniser depth (>=2)
// -----------------------------------------------------------------------------
module cd_tick_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Tick,
    output logic TickPulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Tick};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign TickPulse = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   BCD MM:SS countdown core. Decrements a loadable 4-digit BCD count once per
//   synchronised rising edge of Tick while running, and reports Running/Done.
// Ports
//   Clk, Rst           clock; synchronous active-high reset
//   Tick               1 Hz divider level
//   Load, LoadMin/Sec  load clamped BCD value and return to IDLE
//   Start, Pause       one-cycle control pulses (Pause beats Start)
//   Count              {min_tens,min_units,sec_tens,sec_units}
//   Running, Done      registered state flags
//   DonePulse          one cycle on entry to DONE
//   Blank              display blank request
// Configuration
//   DONE_BLINK_EN      when defined, Blank toggles on each tick while in DONE;
//                      otherwise Blank is tied low.
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RST_MIN     = 8'h00,
    parameter logic [7:0]  RST_SEC     = 8'h00
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tick,
    input  logic        Load,
    input  logic [7:0]  LoadMin,
    input  logic [7:0]  LoadSec,
    input  logic        Start,
    input  logic        Pause,
    output logic [15:0] Count,
    output logic        Running,
    output logic        Done,
    output logic        DonePulse,
    output logic        Blank
);

    logic        w_tick;
    cd_state_t   r_state, w_state_next;
    logic [15:0] r_count, w_count_next, w_count_dec;
    logic        r_running, r_done, r_done_pulse, w_done_pulse_next;

    cd_tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .TickPulse(w_tick)
    );

    // One-second borrow chain. Only used in RUN, where Count is never 0000.
    always_comb begin
        w_count_dec = r_count;
        if (r_count[3:0] != 4'd0) begin
            w_count_dec[3:0] = r_count[3:0] - 4'd1;
        end else begin
            w_count_dec[3:0] = BCD_MAX_UNITS;
            if (r_count[7:4] != 4'd0) begin
                w_count_dec[7:4] = r_count[7:4] - 4'd1;
            end else begin
                w_count_dec[7:4] = BCD_MAX_SECT;
                if (r_count[11:8] != 4'd0) begin
                    w_count_dec[11:8] = r_count[11:8] - 4'd1;
                end else begin
                    w_count_dec[11:8]  = BCD_MAX_UNITS;
                    w_count_dec[15:12] = r_count[15:12] - 4'd1;
                end
            end
        end
    end

    // Priority: Load > Pause > Start > tick. A Start that coincides with a
    // Pause is dropped, and a tick outside RUN is simply discarded.
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_done_pulse_next = 1'b0;
        if (Load) begin
            w_count_next = bcd_clamp(LoadMin, LoadSec);
            w_state_next = IDLE;
        end else if (Pause && (r_state == RUN)) begin
            w_state_next = PAUSE;
        end else if (Start && !Pause && ((r_state == IDLE) || (r_state == PAUSE))) begin
            if (r_count != 16'h0000) begin
                w_state_next = RUN;
            end else begin
                w_state_next      = DONE;
                w_done_pulse_next = 1'b1;
            end
        end else if (w_tick && (r_state == RUN)) begin
            w_count_next = w_count_dec;
            if (w_count_dec == 16'h0000) begin
                w_state_next      = DONE;
                w_done_pulse_next = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_count      <= {RST_MIN, RST_SEC};
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_running    <= (w_state_next == RUN);
            r_done       <= (w_state_next == DONE);
            r_done_pulse <= w_done_pulse_next;
        end
    end

`ifdef DONE_BLINK_EN
    logic r_blank;

    // Toggle only on ticks seen while already in DONE; any exit clears it.
    always_ff @(posedge Clk) begin
        if (Rst || (w_state_next != DONE)) begin
            r_blank <= 1'b0;
        end else if ((r_state == DONE) && w_tick) begin
            r_blank <= ~r_blank;
        end
    end

    assign Blank = r_blank;
`else
    assign Blank = 1'b0;
`endif

    assign Count     = r_count;
    assign Running   = r_running;
    assign Done      = r_done;
    assign DonePulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Self-checking bench for countdown_timer. The reference model keeps the
//   remaining time as a plain number of seconds and a mode number, and models
//   the tick path as a history of sampled Tick levels.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int SYNC = 2;
    localparam int HL   = SYNC + 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Tick = 1'b0;
    logic        Load = 1'b0;
    logic [7:0]  LoadMin = 8'h00;
    logic [7:0]  LoadSec = 8'h00;
    logic        Start = 1'b0;
    logic        Pause = 1'b0;
    logic [15:0] Count;
    logic        Running, Done, DonePulse, Blank;

    countdown_timer #(
        .SYNC_STAGES(SYNC),
        .RST_MIN    (8'h00),
        .RST_SEC    (8'h00)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .Load     (Load),
        .LoadMin  (LoadMin),
        .LoadSec  (LoadSec),
        .Start    (Start),
        .Pause    (Pause),
        .Count    (Count),
        .Running  (Running),
        .Done     (Done),
        .DonePulse(DonePulse),
        .Blank    (Blank)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dp_seen  = 0;

    // Reference model state
    int m_secs  = 0;
    int m_mode  = M_IDLE;
    bit m_dp    = 1'b0;
    bit m_blank = 1'b0;
    bit hist [HL];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [15:0] exp_count();
        int m, s;
        m = m_secs / 60;
        s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit pulse;
        int old_mode;
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = Tick;
        pulse = hist[SYNC] && !hist[SYNC+1];
        old_mode = m_mode;
        m_dp = 1'b0;
        if (Rst) begin
            m_secs  = 0;
            m_mode  = M_IDLE;
            m_blank = 1'b0;
            for (int i = 0; i < HL; i++) hist[i] = 1'b0;
        end else begin
            if (Load) begin
                m_secs = 60 * (10 * clampi(int'(LoadMin[7:4]), 9) + clampi(int'(LoadMin[3:0]), 9))
                       + 10 * clampi(int'(LoadSec[7:4]), 5) + clampi(int'(LoadSec[3:0]), 9);
                m_mode = M_IDLE;
            end else if (Pause && m_mode == M_RUN) begin
                m_mode = M_PAUSE;
            end else if (Start && !Pause && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
                if (m_secs > 0) m_mode = M_RUN;
                else begin m_mode = M_DONE; m_dp = 1'b1; end
            end else if (pulse && m_mode == M_RUN) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin m_mode = M_DONE; m_dp = 1'b1; end
            end
`ifdef DONE_BLINK_EN
            if (m_mode != M_DONE) m_blank = 1'b0;
            else if (old_mode == M_DONE && pulse) m_blank = !m_blank;
`else
            m_blank = 1'b0;
`endif
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge Clk);
        #1;
        if (DonePulse) dp_seen++;
        check("count",   Count, exp_count());
        check("running", 16'(Running),   16'(m_mode == M_RUN));
        check("done",    16'(Done),      16'(m_mode == M_DONE));
        check("dpulse",  16'(DonePulse), 16'(m_dp));
        check("blank",   16'(Blank),     16'(m_blank));
    endtask

    task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
        LoadMin = mn; LoadSec = sc; Load = 1'b1;
        cyc();
        Load = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1; cyc(); Start = 1'b0;
    endtask

    task automatic do_pause();
        Pause = 1'b1; cyc(); Pause = 1'b0;
    endtask

    task automatic tick_edge();
        Tick = 1'b1; repeat (4) cyc();
        Tick = 1'b0; repeat (4) cyc();
    endtask

    int tick_hold = 0;

    initial begin
        for (int i = 0; i < HL; i++) hist[i] = 1'b0;
        #1;
        // 1: reset state, ticks in IDLE ignored
        Rst = 1'b1; repeat (2) cyc(); Rst = 1'b0;
        check("rst_count", Count, 16'h0000);
        check("rst_flags", {12'h000, Running, Done, DonePulse, Blank}, 16'h0000);
        repeat (5) tick_edge();
        check("idle_ticks", Count, 16'h0000);

        // 2: 01:00 -> 00:59 exactly SYNC+1 cycles after the edge
        do_load(8'h01, 8'h00);
        do_start();
        Tick = 1'b1;
        repeat (SYNC) cyc();
        check("lat_before", Count, 16'h0100);
        cyc();
        check("lat_at", Count, 16'h0059);
        repeat (2) cyc();
        Tick = 1'b0; repeat (4) cyc();

        // 3: 00:02 down to DONE, single DonePulse, held afterwards
        do_load(8'h00, 8'h02);
        do_start();
        dp_seen = 0;
        repeat (2) tick_edge();
        check("done_count", Count, 16'h0000);
        check("done_flag", 16'(Done), 16'h0001);
        check("done_pulses", 16'(dp_seen), 16'h0001);
        repeat (3) tick_edge();
        check("done_hold", Count, 16'h0000);
        check("done_pulses_after", 16'(dp_seen), 16'h0001);

        // 4: pause freezes the count, resume continues
        do_load(8'h10, 8'h00);
        do_start();
        tick_edge();
        check("run_0959", Count, 16'h0959);
        do_pause();
        repeat (3) tick_edge();
        check("paused_0959", Count, 16'h0959);
        do_start();
        tick_edge();
        check("resume_0958", Count, 16'h0958);

        // 5: clamped load, Start+Pause together in RUN pauses
        do_load(8'hAB, 8'h7C);
        check("clamp", Count, 16'h9959);
        do_start();
        check("clamp_run", 16'(Running), 16'h0001);
        Start = 1'b1; Pause = 1'b1; cyc(); Start = 1'b0; Pause = 1'b0;
        check("sp_pause", 16'(Running), 16'h0000);
        tick_edge();
        check("sp_hold", Count, 16'h9959);

        // 6: Load mid-RUN returns to IDLE with the new value
        do_load(8'h05, 8'h30);
        do_start();
        do_load(8'h02, 8'h00);
        check("reload_count", Count, 16'h0200);
        check("reload_run", 16'(Running), 16'h0000);
        tick_edge();
        check("reload_idle", Count, 16'h0200);

`ifdef DONE_BLINK_EN
        do_load(8'h00, 8'h01);
        do_start();
        tick_edge();
        check("blink_enter", 16'(Blank), 16'h0000);
        tick_edge();
        check("blink_1", 16'(Blank), 16'h0001);
        tick_edge();
        check("blink_0", 16'(Blank), 16'h0000);
        tick_edge();
        check("blink_2", 16'(Blank), 16'h0001);
        do_load(8'h00, 8'h05);
        check("blink_load", 16'(Blank), 16'h0000);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            Rst   = ($urandom_range(0, 999) == 0);
            Load  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 0) begin
                LoadMin = 8'($urandom);
                LoadSec = 8'($urandom);
            end else begin
                LoadMin = 8'h00;
                LoadSec = {4'h0, 4'($urandom_range(0, 15))};
            end
            Start = ($urandom_range(0, 15) == 0);
            Pause = (m_mode == M_RUN || !Start) ? ($urandom_range(0, 19) == 0) : 1'b0;
            if (tick_hold == 0) begin
                Tick = ~Tick;
                tick_hold = $urandom_range(1, 6);
            end else begin
                tick_hold--;
            end
            cyc();
        end
        Rst = 1'b0; Load = 1'b0; Start = 1'b0; Pause = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
